branch_predictor_btb: RTL

- Direct-mapped branch target buffer with 2-bit saturating direction counters.
- Fetch stage reads it each cycle with the current PC to get a predicted next PC.
- Execute stage writes it with the resolved outcome: `take_branch` from the branch comparison unit plus the computed target.
- On a mispredict it produces the pipeline redirect/flush request.

---
 rtl/branch_predictor_btb_pkg.sv | 30 +++
 rtl/branch_predictor_btb_sat_counter2.sv | 22 ++
 rtl/branch_predictor_btb.sv | 108 ++++++++++
 3 files changed

// File: rtl/branch_predictor_btb_pkg.sv
// Shared types for the branch target buffer.
//   bht_cnt_t    : 2-bit saturating direction counter encoding
//   btb_entry_t  : one BTB entry (valid, tag, target, counter)
//   CNT_ALLOC    : counter value given to a freshly allocated entry
//   CNT_RESET    : counter value held by every entry after reset
// The tag field is sized for the smallest legal table (2 entries) so one
// entry type serves every ENTRIES value; narrower tags are zero-extended.
package branch_predictor_btb_pkg;

  localparam int BTB_PC_W      = 32;
  localparam int BTB_TAG_MAX_W = 29;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } bht_cnt_t;

  localparam bht_cnt_t CNT_ALLOC = CNT_WT;
  localparam bht_cnt_t CNT_RESET = CNT_WNT;

  typedef struct packed {
    logic                     valid;
    logic [BTB_TAG_MAX_W-1:0] tag;
    logic [BTB_PC_W-1:0]      target;
    bht_cnt_t                 cnt;
  } btb_entry_t;

endpackage

// File: rtl/branch_predictor_btb_sat_counter2.sv
// Next-state logic of a 2-bit saturating direction counter.
//   cnt      : current counter value
//   inc      : 1 = step towards strongly taken, 0 = towards strongly not taken
//   cnt_next : saturated next value
module sat_counter2
  import branch_predictor_btb_pkg::*;
(
  input  bht_cnt_t cnt,
  input  logic     inc,
  output bht_cnt_t cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (inc) begin
      if (cnt != CNT_ST) cnt_next = bht_cnt_t'(cnt + 2'd1);
    end else begin
      if (cnt != CNT_SNT) cnt_next = bht_cnt_t'(cnt - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Fetch looks up if_pc combinationally; execute trains the table on the
// next clock edge and raises a same-cycle redirect on a mispredict.
//   clk, rst_n                    : clock, async active-low reset
//   if_pc                         : fetch PC
//   if_pred_taken/if_pred_target  : prediction for if_pc
//   ex_*                          : resolved EX-stage instruction
//   redirect_valid/redirect_pc    : flush request and correct next PC
//   perf_branches/perf_mispredicts: free-running event counters
module branch_predictor_btb
  import branch_predictor_btb_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_target,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_take_branch,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  btb_entry_t table_q [ENTRIES];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  btb_entry_t       if_entry, ex_entry;
  logic             if_hit, ex_hit;
  logic [31:0]      if_pc_seq, ex_pc_seq;
  logic             ex_live, upd;
  logic             branch_mispredict, stale_mispredict;
  bht_cnt_t         cnt_next;

  assign if_idx    = if_pc[IDX_W+1:2];
  assign if_tag    = if_pc[31:IDX_W+2];
  assign ex_idx    = ex_pc[IDX_W+1:2];
  assign ex_tag    = ex_pc[31:IDX_W+2];
  assign if_pc_seq = if_pc + 32'd4;
  assign ex_pc_seq = ex_pc + 32'd4;

  // Lookup: reads the registered table, so a same-cycle update of the
  // same index is not visible until after the edge.
  assign if_entry       = table_q[if_idx];
  assign if_hit         = if_entry.valid && (if_entry.tag == BTB_TAG_MAX_W'(if_tag));
  assign if_pred_taken  = if_hit && if_entry.cnt[1];
  assign if_pred_target = if_pred_taken ? if_entry.target : if_pc_seq;

  assign ex_entry = table_q[ex_idx];
  assign ex_hit   = ex_entry.valid && (ex_entry.tag == BTB_TAG_MAX_W'(ex_tag));
  assign ex_live  = ex_valid && !ex_stall;
  assign upd      = ex_live && ex_is_branch;

  // A correctly predicted taken branch can still mispredict if the cached
  // target is stale. A non-branch predicted taken hit an aliased entry.
  assign branch_mispredict = ex_is_branch &&
                             ((ex_take_branch != ex_pred_taken) ||
                              (ex_take_branch && ex_pred_taken && (ex_pred_target != ex_target)));
  assign stale_mispredict  = !ex_is_branch && ex_pred_taken;
  assign redirect_valid    = ex_live && (branch_mispredict || stale_mispredict);
  assign redirect_pc       = (redirect_valid && ex_is_branch && ex_take_branch) ? ex_target : ex_pc_seq;

  sat_counter2 u_sat_counter2 (
    .cnt      (ex_entry.cnt),
    .inc      (ex_take_branch),
    .cnt_next (cnt_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_RESET};
      end
    end else if (upd) begin
      if (ex_hit) begin
        table_q[ex_idx].cnt <= cnt_next;
        if (ex_take_branch) table_q[ex_idx].target <= ex_target;
      end else if (ex_take_branch) begin
        table_q[ex_idx] <= '{valid: 1'b1, tag: BTB_TAG_MAX_W'(ex_tag),
                             target: ex_target, cnt: CNT_ALLOC};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (upd)            perf_branches    <= perf_branches + 32'd1;
      if (redirect_valid) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end

endmodule
